// File: rtl/regfile_pkg.sv
// Shared constants and types for the general-purpose register file.
//   DATA_WIDTH / ADDR_WIDTH : default register and address widths
//   NUM_REGS                : register count derived from ADDR_WIDTH
//   reg_addr_t / reg_data_t : address and data types at the default widths
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 3;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_mux.sv
// Combinational NUM_REGS-to-1 read selector, one instance per read port.
// Ports:
//   regs : register contents (2**ADDR_WIDTH entries of DATA_WIDTH bits)
//   sel  : read address
//   data : contents of regs[sel], zero latency
module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
  input  logic [ADDR_WIDTH-1:0] sel,
  output logic [DATA_WIDTH-1:0] data
);

  // Full decode: every sel value maps to an existing entry.
  always_comb begin
    data = regs[sel];
  end

endmodule

// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one
// synchronous write port, synchronous active-low reset.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
// Ports:
//   clock         : system clock, rising-edge updates
//   resetN        : synchronous active-low reset, clears every register
//   regWrite      : write enable, sampled at the rising edge
//   writeRegister : write address
//   writeData     : write data
//   readRegister1 : read address, port 1
//   readRegister2 : read address, port 2
//   readData1     : contents of readRegister1 (combinational)
//   readData2     : contents of readRegister2 (combinational)
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int unsigned REG_COUNT = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regStore [REG_COUNT];
  logic [DATA_WIDTH-1:0] regView  [REG_COUNT];
  logic                  writeEnable;

  // Write qualification; address 0 is read-only when hardwired.
  always_comb begin
`ifdef ZERO_REG_EN
    writeEnable = regWrite && (writeRegister != '0);
`else
    writeEnable = regWrite;
`endif
  end

  // Storage: reset has priority over a same-cycle write.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regStore[i] <= '0;
      end
    end else if (writeEnable) begin
      regStore[writeRegister] <= writeData;
    end
  end

  // Read-side view; forcing entry 0 keeps it zero even before the first reset.
  always_comb begin
    regView = regStore;
`ifdef ZERO_REG_EN
    regView[0] = '0;
`endif
  end

  regfile_read_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) readMux1 (
    .regs(regView),
    .sel (readRegister1),
    .data(readData1)
  );

  regfile_read_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) readMux2 (
    .regs(regView),
    .sel (readRegister2),
    .data(readData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: expectations are queued when
// stimulus is driven and popped when the read ports are sampled.
module tb_register_file;
  import regfile_pkg::*;

`ifdef ZERO_REG_EN
  localparam bit ZeroRegEn = 1'b1;
`else
  localparam bit ZeroRegEn = 1'b0;
`endif

  typedef struct {
    string     tag;
    reg_data_t d1;
    reg_data_t d2;
  } exp_t;

  logic      clock = 1'b0;
  logic      resetN;
  logic      regWrite;
  reg_addr_t writeRegister;
  reg_data_t writeData;
  reg_addr_t readRegister1;
  reg_addr_t readRegister2;
  reg_data_t readData1;
  reg_data_t readData2;

  exp_t      sbQ[$];
  reg_data_t model [NUM_REGS];
  int        checks = 0;
  int        errors = 0;

  register_file dut (
    .clock        (clock),
    .resetN       (resetN),
    .regWrite     (regWrite),
    .writeRegister(writeRegister),
    .writeData    (writeData),
    .readRegister1(readRegister1),
    .readRegister2(readRegister2),
    .readData1    (readData1),
    .readData2    (readData2)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    exp_t e;
    @(negedge clock);
    resetN = 1'b0; regWrite = 1'b0; writeRegister = '0; writeData = '0;
    @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      readRegister1 = reg_addr_t'(i);
      readRegister2 = reg_addr_t'(7 - i);
      sbQ.push_back('{$sformatf("reset_read_%0d", i), 8'h00, 8'h00});
      #1;
      e = sbQ.pop_front();
      checks++;
      if (readData1 !== e.d1 || readData2 !== e.d2) begin
        errors++;
        $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
      end
    end
  endtask

  task automatic test_write();
    exp_t e;
    @(negedge clock);
    regWrite = 1'b1; writeRegister = 3'd2; writeData = 8'd3;
    readRegister1 = 3'd0; readRegister2 = 3'd2;
    sbQ.push_back('{"write2_before_edge", 8'h00, 8'h00});
    sbQ.push_back('{"write2_after_edge", 8'h00, 8'h03});
    #1;
    e = sbQ.pop_front();
    checks++;
    if (readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", e.tag, readData2, e.d2);
    end
    @(posedge clock); #1;
    e = sbQ.pop_front();
    checks++;
    if (readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", e.tag, readData2, e.d2);
    end
    @(negedge clock);
    regWrite = 1'b0; writeData = 8'd5;
    sbQ.push_back('{"write2_disabled_hold", 8'h00, 8'h03});
    @(posedge clock); #1;
    e = sbQ.pop_front();
    checks++;
    if (readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", e.tag, readData2, e.d2);
    end
  endtask

  task automatic test_write_edge();
    exp_t e;
    @(negedge clock);
    regWrite = 1'b1; writeRegister = 3'd7; writeData = 8'd5;
    readRegister1 = 3'd7; readRegister2 = 3'd2;
    sbQ.push_back('{"write7_before_edge", 8'h00, 8'h03});
    sbQ.push_back('{"write7_after_edge", 8'h05, 8'h03});
    sbQ.push_back('{"write7_disabled_hold", 8'h05, 8'h03});
    @(posedge clock);
    e = sbQ.pop_front();
    checks++;
    // Sampled exactly at the edge: the old value must still be visible.
    if (readData1 !== e.d1 || readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
    end
    #1;
    e = sbQ.pop_front();
    checks++;
    if (readData1 !== e.d1 || readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
    end
    @(negedge clock);
    regWrite = 1'b0; writeData = 8'd4;
    @(posedge clock); #1;
    e = sbQ.pop_front();
    checks++;
    if (readData1 !== e.d1 || readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
    end
  endtask

  task automatic test_same_addr();
    exp_t e;
    @(negedge clock);
    regWrite = 1'b1; writeRegister = 3'd2; writeData = 8'hFF;
    readRegister1 = 3'd2; readRegister2 = 3'd2;
    sbQ.push_back('{"same_addr_before_edge", 8'h03, 8'h03});
    sbQ.push_back('{"same_addr_after_edge", 8'hFF, 8'hFF});
    #1;
    e = sbQ.pop_front();
    checks++;
    if (readData1 !== e.d1 || readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
    end
    @(posedge clock); #1;
    e = sbQ.pop_front();
    checks++;
    if (readData1 !== e.d1 || readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
    end
    @(negedge clock);
    regWrite = 1'b0;
  endtask

  task automatic test_reset_priority();
    exp_t e;
    @(negedge clock);
    resetN = 1'b0; regWrite = 1'b1; writeRegister = 3'd4; writeData = 8'hAA;
    @(posedge clock);
    @(negedge clock);
    resetN = 1'b1; regWrite = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
    readRegister1 = 3'd4; readRegister2 = 3'd7;
    sbQ.push_back('{"reset_beats_write", 8'h00, 8'h00});
    #1;
    e = sbQ.pop_front();
    checks++;
    if (readData1 !== e.d1 || readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    @(negedge clock);
    regWrite = 1'b1; writeRegister = 3'd0; writeData = 8'h55;
    readRegister1 = 3'd0; readRegister2 = 3'd0;
    sbQ.push_back('{"zero_reg_before_edge", 8'h00, 8'h00});
    sbQ.push_back('{"zero_reg_after_edge", ZeroRegEn ? 8'h00 : 8'h55, ZeroRegEn ? 8'h00 : 8'h55});
    #1;
    e = sbQ.pop_front();
    checks++;
    if (readData1 !== e.d1 || readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
    end
    @(posedge clock); #1;
    e = sbQ.pop_front();
    checks++;
    if (readData1 !== e.d1 || readData2 !== e.d2) begin
      errors++;
      $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
    end
    if (!ZeroRegEn) model[0] = 8'h55;
    @(negedge clock);
    regWrite = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t      e;
    reg_data_t d;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      @(negedge clock);
      d = reg_data_t'($urandom_range(255, 0));
      regWrite = 1'b1; writeRegister = reg_addr_t'(i); writeData = d;
      readRegister1 = reg_addr_t'(i);
      readRegister2 = reg_addr_t'((i + 7) % 8);
      sbQ.push_back('{$sformatf("b2b_pre_%0d", i), model[i], model[(i + 7) % 8]});
      #1;
      e = sbQ.pop_front();
      checks++;
      if (readData1 !== e.d1 || readData2 !== e.d2) begin
        errors++;
        $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
      end
      @(posedge clock);
      if (!(ZeroRegEn && i == 0)) model[i] = d;
    end
    @(negedge clock);
    regWrite = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      readRegister1 = reg_addr_t'(i);
      readRegister2 = reg_addr_t'(7 - i);
      sbQ.push_back('{$sformatf("b2b_readback_%0d", i), model[i], model[7 - i]});
      #1;
      e = sbQ.pop_front();
      checks++;
      if (readData1 !== e.d1 || readData2 !== e.d2) begin
        errors++;
        $display("FAIL %s: got %h/%h, expected %h/%h", e.tag, readData1, readData2, e.d1, e.d2);
      end
    end
  endtask

  initial begin
    resetN = 1'b0; regWrite = 1'b0; writeRegister = '0; writeData = '0;
    readRegister1 = '0; readRegister2 = '0;
    test_reset();
    test_write();
    test_write_edge();
    test_same_addr();
    test_reset_priority();
    test_zero_reg();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
Multi-port general-purpose register file for the CPU datapath: two asynchronous (combinational) read ports and one synchronous write port. Default configuration is 8 registers of 8 bits. The decode stage drives the read addresses; the write-back stage drives the write port.

Parameters:
DATA_WIDTH, 8, width of each register and of the data ports
ADDR_WIDTH, 3, width of the register address ports
NUM_REGS, 2**ADDR_WIDTH (8), number of registers; derived, not overridable

Ports:
clock  input  1  system clock; all state updates on the rising edge
resetN  input  1  synchronous, active-low reset
regWrite  input  1  write enable, sampled on the rising clock edge
writeRegister  input  ADDR_WIDTH  write address
writeData  input  DATA_WIDTH  write data
readRegister1  input  ADDR_WIDTH  read address, port 1
readRegister2  input  ADDR_WIDTH  read address, port 2
readData1  output  DATA_WIDTH  contents of register readRegister1
readData2  output  DATA_WIDTH  contents of register readRegister2

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-low.
- Reset: on a rising edge with resetN=0, all NUM_REGS registers become 0, and both read ports then show 0. Reset has priority over a write in the same cycle.
- Write: on a rising edge with resetN=1 and regWrite=1, register[writeRegister] <= writeData. With regWrite=0, no register changes. Only the edge sample matters; regWrite or writeData glitches between edges have no effect.
- Read: purely combinational. readDataN = register[readRegisterN] continuously, with zero-cycle latency from an address change.
- No write-to-read bypass. During the cycle in which a write is pending, a read of the same address returns the old value. The new value appears immediately after the rising edge that performs the write.
- Both read ports may address the same register, or the write target, simultaneously. No conflict handling is needed.
- All addresses are in range (full decode), with no wrap-around concerns.
- Register 0 is an ordinary writable register unless ZERO_REG_EN is defined.
- Contents before the first reset are unspecified (X in simulation). Benches must reset before checking.

Optional Feature:
Macro ZERO_REG_EN.
- Defined: register 0 is hardwired to zero. Writes to address 0 are silently discarded, and any read port addressing 0 returns 0 regardless of write history.
- Not defined: register 0 behaves like every other register (writable and readable).

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH default constants
  - NUM_REGS
  - typedefs reg_addr_t (ADDR_WIDTH bits) and reg_data_t (DATA_WIDTH bits)
- One sub-module is natural: regfile_read_mux, a combinational NUM_REGS-to-1 selector instantiated once per read port.
- Storage and write decode stay in the top module.

Test Plan:
- Reset, then set readRegister1=0..7 and readRegister2=7..0 in turn -> all reads return 0.
- Write address 2 with data 3: regWrite=1 across one rising edge, with readRegister2=2 held -> readData2 reads the reset value 0 before the edge and 3 after it. Then drop regWrite and change writeData to 5 -> readData2 stays 3.
- Write address 7 with data 5 while readRegister1=7 -> readData1 changes from 0 to 5 exactly at the edge. With regWrite=0 and writeData=4 on the next edge -> readData1 stays 5 and readData2 (address 2) stays 3.
- Simultaneous reset and write (resetN=0, regWrite=1, address 4, data 8'hAA) -> register 4 reads 0 afterwards.
- Same-address reads: readRegister1=readRegister2=2 with a write of 8'hFF to address 2 -> both ports show 3 before the edge and 8'hFF after it.
- Address 0, with and without ZERO_REG_EN: write 8'h55 to address 0 -> reads 8'h55 when the macro is undefined, and 0 when it is defined.
